// File: rtl/angle_pkg.sv
// Shared types and constants for the angle preprocessing stage.
// Float field limits and fixed-point degree constants used by the fold logic.
package angle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_REDUCE = 3'd2,
    ST_FOLD   = 3'd3,
    ST_DONE   = 3'd4
  } angle_state_t;

  localparam int FLT_BIAS    = 127;
  localparam int FLT_MANT_W  = 24;
  localparam int FLT_EXP_INF = 255;

  // deg * 2^frac_w; 360 << 22 still fits in 32 bits.
  function automatic logic [31:0] deg_const(input int deg, input int frac_w);
    logic [31:0] v;
    v = 32'(deg);
    return v << frac_w;
  endfunction

endpackage

// File: rtl/angle_prep_fp32_unpack.sv
// Combinational IEEE-754 single split: sign, mantissa with hidden bit,
// unbiased exponent, and zero/denormal and Inf/NaN flags.
module fp32_unpack
  import angle_pkg::*;
(
  input  logic                  data,
  input  logic [30:0]           body,
  output logic                  sign,
  output logic [FLT_MANT_W-1:0] mant,
  output logic signed [9:0]     exp_unb,
  output logic                  is_zero,
  output logic                  is_special
);

  logic [7:0] exp_raw;

  assign exp_raw    = body[30:23];
  assign sign       = data;
  assign mant       = {1'b1, body[22:0]};
  assign exp_unb    = $signed({2'b00, exp_raw}) - 10'(FLT_BIAS);
  assign is_zero    = (exp_raw == 8'd0);
  assign is_special = (exp_raw == 8'(FLT_EXP_INF));

endmodule

// File: rtl/angle_prep.sv
// Reduces an fp32 angle in degrees exactly modulo 360 (one shift-subtract per
// cycle) and folds it into [-90, +90] with a cosine-negate flag.
module angle_prep
  import angle_pkg::*;
#(
  parameter int FRAC_W  = 16,
  parameter int ANGLE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ANGLE_W-1:0] out_angle,
  output logic               out_neg_cos,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int R_W = FRAC_W + 10;
  localparam int C_W = ((ANGLE_W > R_W) ? ANGLE_W : R_W) + 2;

  localparam logic [R_W-1:0]          M     = R_W'(deg_const(360, FRAC_W));
  localparam logic [R_W:0]            M_X   = (R_W + 1)'(deg_const(360, FRAC_W));
  localparam logic signed [C_W-1:0]   D90   = C_W'(deg_const(90, FRAC_W));
  localparam logic signed [C_W-1:0]   D180  = C_W'(deg_const(180, FRAC_W));
  localparam logic signed [C_W-1:0]   D270  = C_W'(deg_const(270, FRAC_W));
  localparam logic signed [C_W-1:0]   D360  = C_W'(deg_const(360, FRAC_W));
  localparam logic signed [10:0]      S_ADJ = 11'(FRAC_W - (FLT_MANT_W - 1));

  angle_state_t state;

  logic [31:0]    in_reg;
  logic [R_W-1:0] r;
  logic [7:0]     cnt;
  logic           sign_q;
  logic           err_q;

  logic                  u_sign;
  logic [FLT_MANT_W-1:0] u_mant;
  logic signed [9:0]     u_exp;
  logic                  u_zero;
  logic                  u_special;

  fp32_unpack u_unpack (
    .data       (in_reg[31]),
    .body       (in_reg[30:0]),
    .sign       (u_sign),
    .mant       (u_mant),
    .exp_unb    (u_exp),
    .is_zero    (u_zero),
    .is_special (u_special)
  );

  // s is the left shift that places the mantissa LSB at weight 2^-FRAC_W.
  logic signed [10:0] s_val;
  logic [10:0]        rshift;
  logic [R_W-1:0]     mant_ext;
  logic [R_W-1:0]     r_shr;

  assign s_val    = $signed({u_exp[9], u_exp}) + S_ADJ;
  assign rshift   = 11'(-s_val);
  assign mant_ext = R_W'(u_mant);
  assign r_shr    = mant_ext >> rshift;

  // r < M always holds, so a single conditional subtract keeps 2r reduced.
  logic [R_W:0]   r_dbl;
  logic [R_W-1:0] r_next;

  always_comb begin
    r_dbl  = {r, 1'b0};
    r_next = (r_dbl >= M_X) ? R_W'(r_dbl - M_X) : R_W'(r_dbl);
  end

  logic [R_W-1:0]        r_fold;
  logic signed [C_W-1:0] r_s;
  logic signed [C_W-1:0] fold_ang;
  logic                  fold_neg;

  always_comb begin
    r_fold = r;
    if (sign_q && (r != '0)) begin
      r_fold = M - r;
    end
    r_s      = $signed(C_W'(r_fold));
    fold_ang = '0;
    fold_neg = 1'b0;
    if (r_s < D90) begin
      fold_ang = r_s;
    end else if (r_s < D270) begin
      fold_ang = D180 - r_s;
      fold_neg = 1'b1;
    end else begin
      fold_ang = r_s - D360;
    end
    if (err_q) begin
      fold_ang = '0;
      fold_neg = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      in_reg      <= '0;
      r           <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      out_angle   <= '0;
      out_neg_cos <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_reg <= in_data;
            state  <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          sign_q <= u_sign;
          err_q  <= u_special;
          cnt    <= '0;
          if (u_zero || u_special) begin
            r     <= '0;
            state <= ST_FOLD;
          end else if (s_val <= 11'sd0) begin
            r     <= r_shr;
            state <= ST_FOLD;
          end else begin
            r     <= mant_ext;
            cnt   <= 8'(s_val);
            state <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          r   <= r_next;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          out_angle   <= ANGLE_W'(fold_ang);
          out_neg_cos <= fold_neg;
          out_err     <= err_q;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: doc/angle_prep.md
# angle_prep

Preprocessing stage between the AXI-Lite register file and the CORDIC core. Accepts an IEEE-754 single-precision angle in degrees, reduces it exactly modulo 360 with a bit-serial shift-subtract loop, and folds it into [-90, +90]. Emits a signed fixed-point angle plus a cosine-negate flag for the CORDIC output stage. Latency is data-dependent but deterministic (exponent-driven) and bounded.

## Interface
- FRAC_W, 16, fractional bits of the fixed-point angle; legal range 16..22, so 360·2^FRAC_W > 2^24.
- ANGLE_W, 32, output angle width; must be ≥ FRAC_W+9.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  32  IEEE-754 single, degrees.
- in_valid  in  1  input handshake.
- in_ready  out  1  high only in IDLE.
- out_angle  out  ANGLE_W  signed two's-complement degrees, FRAC_W fractional bits, range [-90, +90].
- out_neg_cos  out  1  CORDIC cosine result must be negated.
- out_err  out  1  input was Inf/NaN.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts.

## Operation
- M = 360·2^FRAC_W. Working remainder r is FRAC_W+10 bits wide and unsigned.
- States: IDLE, UNPACK, REDUCE, FOLD, DONE.
- IDLE: in_ready=1. On in_valid, latch in_data, then go to UNPACK.
- UNPACK: split sign, exp, frac.
  - exp=0 (zero/denormal): r=0.
  - exp=255: set err, r=0.
  - Else m={1,frac} (24 bit) and s = exp-127-23+FRAC_W.
    - s≤0: r = m >> -s, truncating toward zero.
    - s>0: r=m and cnt=s.
  - Go to REDUCE if cnt>0, else FOLD.
- REDUCE: one step per cycle: r = 2r; if r ≥ M then r -= M; cnt--. Leave when cnt reaches 0. The maximum is 104+FRAC_W steps (exp=254).
- FOLD, in one cycle:
  - If sign=1 and r≠0, set r = M-r.
  - r < 90·2^F: angle = r, neg_cos=0.
  - 90·2^F ≤ r < 270·2^F: angle = 180·2^F − r, neg_cos=1.
  - Otherwise: angle = r − M, neg_cos=0.
  - If err is set, force angle=0 and neg_cos=0.
  - Register the outputs, then go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE.
- Negative zero gives angle 0, neg_cos 0.

## Timing
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_angle=0; out_neg_cos=0; out_err=0.
- Acceptance occurs on the edge where in_valid && in_ready.
- out_valid rises exactly 2+max(s,0) cycles after the acceptance edge. A NaN or zero input takes 2 cycles.
- Outputs stay stable while out_valid && !out_ready.
- in_ready returns to 1 the cycle after out_valid && out_ready. There is no back-to-back overlap; throughput is one angle per latency+2 cycles.
- in_valid outside IDLE is ignored; the upstream holds it.
- reset asserted in any state: next edge gives IDLE with all outputs at their reset values. The partial result is discarded and never emitted.
- reset has priority over a simultaneous in_valid or out_ready.

## Structure
- Shared package angle_pkg holds:
  - state enum typedef angle_state_t;
  - FLT_BIAS=127, FLT_MANT_W=24, FLT_EXP_INF=255;
  - functions deg_const(deg, frac_w) for the 90/180/270/360 fixed constants.
- One sub-module, fp32_unpack: combinational. Produces sign, mantissa with hidden bit, unbiased exponent, and is_zero/is_special flags.
- The FSM, the reduction datapath and the fold stay in angle_prep.

## Test plan
All cases use FRAC_W=16, ANGLE_W=32.
- 0x43330000 (179.0) → angle 0x00010000, neg_cos 1, err 0, out_valid 2 cycles after accept.
- 0xC1F00000 (−30.0) → angle 0xFFE20000, neg_cos 0, latency 2.
- 0x43480000 (200.0) → angle 0xFFEC0000, neg_cos 1. Also 0x44340000 (720.0) → angle 0, neg_cos 0, latency 4 (s=2).
- 0x7FC00000 (NaN) → err 1, angle 0, neg_cos 0, latency 2. Also 0x80000000 (−0.0) → angle 0, err 0.
- 0x7F7FFFFF (max finite) → out_valid exactly 122 cycles after accept. Angle must match an exact big-integer mod-360 model, truncated to 2^-16.
- Hold out_ready=0 for 5 cycles → outputs stable, in_ready 0. Separately, assert reset mid-REDUCE → IDLE next edge, out_valid never asserted, and a following 179.0 completes normally.
